// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one memory request port between an instruction
// port and a data port. Grants are decided combinationally in IDLE and frozen
// while the memory side stalls the address phase. A small owner FIFO records
// which port issued each accepted request so in-order responses can be routed.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants on
// simultaneous requests; otherwise the data port always wins.
module mem_req_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_cache,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_cache,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [2:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_cache,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD_I = 2'd1;
  localparam logic [1:0] HOLD_D = 2'd2;

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic          grant_valid;
  logic          grant_data;
  logic          full;
  logic          empty;
  logic          blocked;
  logic          push;
  logic          pop;
  logic          head_owner;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          owner_q [DEPTH];

`ifdef ARB_ROUND_ROBIN_EN
  logic          last_data_q;
`endif

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // A full FIFO stalls new requests unless a response frees a slot this cycle
  assign blocked = full && !mem_data_ok;

  // Pick the owner of the shared port: fresh choice in IDLE, frozen in HOLD
  always_comb begin
    grant_valid = 1'b0;
    grant_data  = 1'b0;
    case (state_q)
      IDLE: begin
        grant_valid = inst_req | data_req;
        if (inst_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          grant_data = !last_data_q;
`else
          grant_data = 1'b1;
`endif
        end else begin
          grant_data = data_req;
        end
      end
      HOLD_I: begin
        grant_valid = inst_req;
        grant_data  = 1'b0;
      end
      HOLD_D: begin
        grant_valid = data_req;
        grant_data  = 1'b1;
      end
      default: begin
        grant_valid = 1'b0;
        grant_data  = 1'b0;
      end
    endcase
  end

  assign mem_req      = grant_valid && !blocked;
  assign push         = mem_req && mem_addr_ok;
  assign pop          = mem_data_ok && !empty;
  assign inst_addr_ok = mem_req && !grant_data && mem_addr_ok;
  assign data_addr_ok = mem_req && grant_data && mem_addr_ok;

  // Instruction fetches are always full-word reads; data requests pass through
  always_comb begin
    mem_cache = grant_data ? data_cache : inst_cache;
    mem_addr  = grant_data ? data_addr  : inst_addr;
    mem_wr    = grant_data ? data_wr    : 1'b0;
    mem_wstrb = grant_data ? data_wstrb : 4'b0000;
    mem_size  = grant_data ? data_size  : 3'd2;
    mem_wdata = grant_data ? data_wdata : 32'd0;
  end

  assign head_owner   = owner_q[rd_ptr_q];
  assign inst_data_ok = pop && !head_owner;
  assign data_data_ok = pop && head_owner;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Next grant state: park in HOLD while the address phase is stalled
  always_comb begin
    state_d = state_q;
    if (!blocked) begin
      case (state_q)
        IDLE: begin
          if (mem_req && !mem_addr_ok) begin
            state_d = grant_data ? HOLD_D : HOLD_I;
          end
        end
        HOLD_I: begin
          if (!inst_req || mem_addr_ok) begin
            state_d = IDLE;
          end
        end
        HOLD_D: begin
          if (!data_req || mem_addr_ok) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Grant state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Owner storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      owner_q[wr_ptr_q] <= grant_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky flag for a response that no accepted request is waiting for
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arb_err <= 1'b0;
    end else if (mem_data_ok && empty) begin
      arb_err <= 1'b1;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember which port was granted at the last accepted request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_data_q <= 1'b0;
    end else if (push) begin
      last_data_q <= grant_data;
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed testbench for mem_req_arbiter (DEPTH 4). Expected values are
// hand-derived; grant expectations follow ARB_ROUND_ROBIN_EN when defined.
module tb_mem_req_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_cache;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_cache, data_wr;
  logic [3:0]  data_wstrb;
  logic [2:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_cache, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [2:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        arb_err;

  int checks = 0;
  int errors = 0;
  bit exp_own[$];

  mem_req_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_cache(inst_cache), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_cache(data_cache), .data_wr(data_wr),
    .data_wstrb(data_wstrb), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_cache(mem_cache), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .arb_err(arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task applyStimulus(input logic ir, input logic dr, input logic mao, input logic mdo);
    inst_req    = ir;
    data_req    = dr;
    mem_addr_ok = mao;
    mem_data_ok = mdo;
  endtask

  task nextCycle;
    @(posedge clk);
    #1;
  endtask

  // One response cycle: checks routing against the bench's owner queue
  task drainOne(input logic [31:0] rdata);
    bit own;
    own = exp_own.pop_front();
    mem_rdata = rdata;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("drain_inst_data_ok", inst_data_ok, !own);
    checkOutput("drain_data_data_ok", data_data_ok, own);
    checkOutput("drain_inst_rdata", inst_rdata, rdata);
    checkOutput("drain_data_rdata", data_rdata, rdata);
    nextCycle();
  endtask

  initial begin
    bit exp_data;
    bit seq [4];
    resetn      = 1'b0;
    inst_cache  = 1'b1;
    inst_addr   = 32'h0000_4000;
    data_cache  = 1'b0;
    data_wr     = 1'b1;
    data_wstrb  = 4'hF;
    data_size   = 3'd1;
    data_addr   = 32'h0000_0100;
    data_wdata  = 32'hDEAD_BEEF;
    mem_rdata   = 32'd0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    #2;
    checkOutput("reset_mem_req", mem_req, 1'b0);
    checkOutput("reset_arb_err", arb_err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Both ports requesting with immediate accepts
    for (int i = 0; i < 3; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_data = (i % 2 == 0);
`else
      exp_data = 1'b1;
`endif
      data_addr = 32'h100 + i;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("both_data_addr_ok", data_addr_ok, exp_data);
      checkOutput("both_inst_addr_ok", inst_addr_ok, !exp_data);
      checkOutput("both_mem_addr", mem_addr, exp_data ? 32'h100 + i : 32'h4000);
      checkOutput("both_mem_wr", mem_wr, exp_data);
      checkOutput("both_mem_wstrb", mem_wstrb, exp_data ? 4'hF : 4'h0);
      exp_own.push_back(exp_data);
      nextCycle();
    end
    for (int k = 0; k < 3; k++) drainOne(32'hA000 + k);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("idle_mem_req", mem_req, 1'b0);
    nextCycle();

    // Instruction request stalled three cycles; data arrives meanwhile
    inst_addr = 32'hBFC0_0000;
    data_addr = 32'h0000_2000;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("hold_c0_mem_req", mem_req, 1'b1);
    checkOutput("hold_c0_mem_addr", mem_addr, 32'hBFC0_0000);
    checkOutput("hold_c0_inst_addr_ok", inst_addr_ok, 1'b0);
    nextCycle();
    for (int c = 1; c < 3; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("hold_mem_addr", mem_addr, 32'hBFC0_0000);
      checkOutput("hold_data_addr_ok", data_addr_ok, 1'b0);
      checkOutput("hold_mem_size", mem_size, 3'd2);
      checkOutput("hold_mem_wr", mem_wr, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("hold_accept_inst_addr_ok", inst_addr_ok, 1'b1);
    checkOutput("hold_accept_data_addr_ok", data_addr_ok, 1'b0);
    checkOutput("hold_accept_mem_addr", mem_addr, 32'hBFC0_0000);
    exp_own.push_back(1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("after_hold_data_addr_ok", data_addr_ok, 1'b1);
    checkOutput("after_hold_mem_addr", mem_addr, 32'h0000_2000);
    checkOutput("after_hold_mem_size", mem_size, 3'd1);
    exp_own.push_back(1'b1);
    nextCycle();
    drainOne(32'h1111_0000);
    drainOne(32'h2222_0000);

    // Fill the owner FIFO with I,D,D,I
    seq[0] = 1'b0; seq[1] = 1'b1; seq[2] = 1'b1; seq[3] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      applyStimulus(!seq[n], seq[n], 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("fill_inst_addr_ok", inst_addr_ok, !seq[n]);
      checkOutput("fill_data_addr_ok", data_addr_ok, seq[n]);
      exp_own.push_back(seq[n]);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("full_mem_req", mem_req, 1'b0);
    checkOutput("full_data_addr_ok", data_addr_ok, 1'b0);
    nextCycle();
    // Response and new accept in the same cycle while full
    mem_rdata = 32'h5555_AAAA;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("swap_mem_req", mem_req, 1'b1);
    checkOutput("swap_data_addr_ok", data_addr_ok, 1'b1);
    checkOutput("swap_inst_data_ok", inst_data_ok, 1'b1);
    checkOutput("swap_data_data_ok", data_data_ok, 1'b0);
    void'(exp_own.pop_front());
    exp_own.push_back(1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("still_full_mem_req", mem_req, 1'b0);
    nextCycle();
    for (int k = 0; k < 4; k++) drainOne(32'hC000 + k);

    // Outstanding request dropped by reset, then a stray response
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    nextCycle();
    resetn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    resetn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("stray_inst_data_ok", inst_data_ok, 1'b0);
    checkOutput("stray_data_data_ok", data_data_ok, 1'b0);
    checkOutput("stray_arb_err_before", arb_err, 1'b0);
    nextCycle();
    checkOutput("stray_arb_err_set", arb_err, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("stray_arb_err_sticky", arb_err, 1'b1);
    resetn = 1'b0;
    #1;
    checkOutput("reset_clears_arb_err", arb_err, 1'b0);
    nextCycle();
    resetn = 1'b1;
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter: DEPTH, 4, maximum outstanding accepted-but-unanswered requests (power of two, 2..16).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 inst_req/inst_cache  input  1/1  instruction-port request and cacheable attribute.
REQ-005 inst_addr  input  32  instruction-port address.
REQ-006 inst_addr_ok/inst_data_ok  output  1/1  instruction-port accept and response strobes.
REQ-007 inst_rdata  output  32  instruction-port response data.
REQ-008 data_req/data_cache/data_wr  input  1/1/1  data-port request, cacheable attribute, write flag.
REQ-009 data_wstrb/data_size  input  4/3  data-port byte strobe and size.
REQ-010 data_addr/data_wdata  input  32/32  data-port address and write data.
REQ-011 data_addr_ok/data_data_ok  output  1/1  data-port accept and response strobes.
REQ-012 data_rdata  output  32  data-port response data.
REQ-013 mem_req/mem_cache/mem_wr  output  1/1/1  shared-port request and attributes.
REQ-014 mem_wstrb/mem_size  output  4/3  shared-port byte strobe and size.
REQ-015 mem_addr/mem_wdata  output  32/32  shared-port address and write data.
REQ-016 mem_addr_ok/mem_data_ok  input  1/1  shared-port accept and response strobes.
REQ-017 mem_rdata  input  32  shared-port response data.
REQ-018 arb_err  output  1  sticky flag: mem_data_ok received with no outstanding request.

Function
REQ-019 Grant FSM states IDLE, HOLD_I, HOLD_D; grant computed combinationally in IDLE, so mem_req asserts the same cycle a port request is seen.
REQ-020 IDLE, mem_req high, mem_addr_ok low -> HOLD_I/HOLD_D per granted port; grant frozen there; other port gets no addr_ok.
REQ-021 HOLD_x with mem_addr_ok high -> IDLE; HOLD_x with granted port's req dropped -> IDLE, no transfer.
REQ-022 Granted port sees addr_ok = mem_addr_ok same cycle (zero added latency); ungranted port sees addr_ok 0.
REQ-023 Instruction grant drives mem_wr 0, mem_wstrb 4'b0000, mem_size 3'd2, mem_wdata 0; data grant passes all data_* fields unchanged.
REQ-024 Owner FIFO of DEPTH 1-bit entries (0 inst, 1 data) with occupancy counter 0..DEPTH; push owner on mem_req && mem_addr_ok; pop on mem_data_ok.
REQ-025 Response routing: head 0 -> inst_data_ok = mem_data_ok; head 1 -> data_data_ok = mem_data_ok; the other strobe 0.
REQ-026 inst_rdata and data_rdata both equal mem_rdata unconditionally.
REQ-027 Counter == DEPTH (full) -> mem_req forced 0, both addr_ok 0, FSM state held.
REQ-028 Simultaneous push and pop -> counter unchanged, pointers both advance; legal when full (pop frees slot same cycle, push admitted).
REQ-029 mem_data_ok with counter 0 -> no pop, both data_ok 0, arb_err set until reset.
REQ-030 FIFO pointers wrap modulo DEPTH.

Reset
REQ-031 resetn low -> asynchronously: FSM IDLE, counter 0, pointers 0, arb_err 0, round-robin pointer to instruction-last; outputs combinational from that state.
REQ-032 Reset mid-transfer drops all outstanding ownership; responses arriving after reset release count as spurious (REQ-029).

Configuration
REQ-033 Macro ARB_ROUND_ROBIN_EN defined: in IDLE with both requests high, grant the port not granted at last push; pointer updates on each push.
REQ-034 ARB_ROUND_ROBIN_EN undefined: data port always wins simultaneous IDLE requests; no pointer register.

Verification
REQ-035 Both req high in IDLE, mem_addr_ok 1 every cycle, undefined macro -> data accepted every cycle, inst_addr_ok stays 0.
REQ-036 Same stimulus with ARB_ROUND_ROBIN_EN -> grants alternate D,I,D,I (first grant data, since reset pointer = instruction-last).
REQ-037 Inst req at 0xBFC00000, mem_addr_ok delayed 3 cycles, data_req asserted cycle 1 -> mem_addr stays 0xBFC00000 until accept, then data granted.
REQ-038 Issue I,D,D,I with DEPTH 4, no responses -> 5th request sees mem_req 0; then 4 mem_data_ok pulses -> inst,data,data,inst data_ok order.
REQ-039 Full FIFO, same-cycle mem_data_ok and mem_addr_ok -> count stays 4, new owner at tail.
REQ-040 mem_data_ok with counter 0 -> arb_err 1, no data_ok; resetn pulse low -> arb_err 0.
